mobo_mem_responder: RTL and testbench

//  Motherboard-side responder for the CPU mobo_ctrl/mobo_stat read/write handshake.
//  - Decodes CTRL_READ / CTRL_WRITE from the CPU and performs the access on an internal word RAM.
//  - Models access latency.
//  - Reports STAT_IDLE / STAT_BUSY / STAT_DONE back to the CPU function states.
//  - Sits between the CPU core and the memory map. The bench uses it as the CPU's memory model.

---
 rtl/mobo_mem_responder.sv | 99 +++++++++
 tb/tb_mobo_mem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mobo_mem_responder.sv
// mobo_mem_responder: motherboard-side word RAM responder for the CPU mobo_ctrl/mobo_stat handshake,
// with modelled access latency and saturating read/write counters.
`ifndef MOBO_DEFS
`define MOBO_DEFS
`define WORD_WIDTH 32
`define CTRL_NONE  0
`define CTRL_READ  1
`define CTRL_WRITE 2
`define STAT_IDLE  0
`define STAT_BUSY  1
`define STAT_DONE  2
`endif

module mobo_mem_responder #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] mobo_ctrl,
    input  logic [WORD_WIDTH-1:0] mobo_addr,
    input  logic [WORD_WIDTH-1:0] mobo_wdata,
    output logic [WORD_WIDTH-1:0] mobo_stat,
    output logic [WORD_WIDTH-1:0] mobo_rdata,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [WORD_WIDTH-1:0] CTRL_NONE  = WORD_WIDTH'(`CTRL_NONE);
    localparam logic [WORD_WIDTH-1:0] CTRL_READ  = WORD_WIDTH'(`CTRL_READ);
    localparam logic [WORD_WIDTH-1:0] CTRL_WRITE = WORD_WIDTH'(`CTRL_WRITE);

    typedef enum logic [1:0] {
        IDLE = 2'(`STAT_IDLE),
        BUSY = 2'(`STAT_BUSY),
        DONE = 2'(`STAT_DONE)
    } state_e;

    state_e                  state_q;
    logic [7:0]              lat_q;
    logic                    op_wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic [WORD_WIDTH-1:0]   rdata_q;
    logic [CNT_WIDTH-1:0]    rd_cnt_q;
    logic [CNT_WIDTH-1:0]    wr_cnt_q;
    logic [WORD_WIDTH-1:0]   ram [DEPTH];
    logic                    ram_we;

    // The write fires only on the completion edge, so an async reset during BUSY discards it.
    assign ram_we = (state_q == BUSY) && (lat_q == 8'd0) && op_wr_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (mobo_ctrl == CTRL_READ || mobo_ctrl == CTRL_WRITE) begin
                    op_wr_q <= (mobo_ctrl == CTRL_WRITE);
                    addr_q  <= mobo_addr[ADDR_WIDTH-1:0];
                    wdata_q <= mobo_wdata;
                    lat_q   <= 8'(LATENCY - 1);
                    state_q <= BUSY;
                end
                BUSY: if (lat_q != 8'd0) begin
                    lat_q <= lat_q - 8'd1;
                end else begin
                    if (op_wr_q) begin
                        wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(~&wr_cnt_q);
                    end else begin
                        rdata_q  <= ram[addr_q];
                        rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(~&rd_cnt_q);
                    end
                    state_q <= DONE;
                end
                DONE: if (mobo_ctrl == CTRL_NONE) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mobo_stat  = WORD_WIDTH'(state_q);
    assign mobo_rdata = rdata_q;
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;
endmodule

// File: tb/tb_mobo_mem_responder.sv
// tb_mobo_mem_responder: directed checks of the mobo memory responder across latency and counter-width variants.
module tb_mobo_mem_responder;
    localparam logic [31:0] NONE = 32'd0, RD = 32'd1, WR = 32'd2;
    localparam logic [31:0] S_IDLE = 32'd0, S_BUSY = 32'd1, S_DONE = 32'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl [4];
    logic [31:0] addr [4];
    logic [31:0] wd [4];
    logic [31:0] stat [4];
    logic [31:0] rdata [4];
    logic [15:0] rdc [3];
    logic [15:0] wrc [3];
    logic [1:0]  s_rdc, s_wrc;
    int          checks = 0;
    int          errors = 0;
    int          bw;

    always #5 clk = ~clk;

    mobo_mem_responder #(.LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .mobo_ctrl(ctrl[0]), .mobo_addr(addr[0]),
        .mobo_wdata(wd[0]), .mobo_stat(stat[0]), .mobo_rdata(rdata[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));
    mobo_mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .mobo_ctrl(ctrl[1]), .mobo_addr(addr[1]),
        .mobo_wdata(wd[1]), .mobo_stat(stat[1]), .mobo_rdata(rdata[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));
    mobo_mem_responder #(.LATENCY(255)) dut2 (.clk(clk), .rst_n(rst_n), .mobo_ctrl(ctrl[2]), .mobo_addr(addr[2]),
        .mobo_wdata(wd[2]), .mobo_stat(stat[2]), .mobo_rdata(rdata[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));
    mobo_mem_responder #(.LATENCY(2), .CNT_WIDTH(2)) dut3 (.clk(clk), .rst_n(rst_n), .mobo_ctrl(ctrl[3]),
        .mobo_addr(addr[3]), .mobo_wdata(wd[3]), .mobo_stat(stat[3]), .mobo_rdata(rdata[3]),
        .rd_count(s_rdc), .wr_count(s_wrc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (stat[k] == S_BUSY && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("reach_done", stat[k], S_DONE);
    endtask

    task automatic access(input int k, input logic [31:0] op, input logic [31:0] a, input logic [31:0] d,
                          output int n);
        @(negedge clk);
        ctrl[k] = op; addr[k] = a; wd[k] = d;
        @(negedge clk);
        wait_done(k, n);
        ctrl[k] = NONE;
        @(negedge clk);
        chk("back_idle", stat[k], S_IDLE);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            ctrl[k] = NONE; addr[k] = '0; wd[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_stat", stat[0], S_IDLE);
        chk("reset_rdata", rdata[0], 32'h0);
        chk("reset_rdc", 32'(rdc[0]), 32'h0);

        // reset aborts a pending write
        access(0, WR, 32'd3, 32'h11, bw);
        access(0, RD, 32'd3, 32'h0, bw);
        chk("pre_rd3", rdata[0], 32'h11);
        @(negedge clk);
        ctrl[0] = WR; addr[0] = 32'd3; wd[0] = 32'h55;
        @(negedge clk);
        chk("abort_busy", stat[0], S_BUSY);
        rst_n = 1'b0;
        #1;
        chk("abort_stat", stat[0], S_IDLE);
        chk("abort_rdata", rdata[0], 32'h0);
        ctrl[0] = NONE;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, RD, 32'd3, 32'h0, bw);
        chk("abort_rd3", rdata[0], 32'h11);

        // basic write/read at LATENCY=2
        access(0, WR, 32'h10, 32'hDEADBEEF, bw);
        chk("wr_busy_w", bw, 2);
        access(0, RD, 32'h10, 32'h0, bw);
        chk("rd_busy_w", bw, 2);
        chk("rd_data", rdata[0], 32'hDEADBEEF);
        chk("wr_count", 32'(wrc[0]), 32'd1);
        chk("rd_count", 32'(rdc[0]), 32'd2);

        // command held through DONE does not retrigger
        @(negedge clk);
        ctrl[0] = RD; addr[0] = 32'h10;
        @(negedge clk);
        wait_done(0, bw);
        repeat (5) @(negedge clk);
        chk("hold_done", stat[0], S_DONE);
        ctrl[0] = WR;
        @(negedge clk);
        chk("swap_done", stat[0], S_DONE);
        chk("hold_rdc", 32'(rdc[0]), 32'd3);
        chk("hold_wrc", 32'(wrc[0]), 32'd1);
        ctrl[0] = NONE;
        @(negedge clk);
        chk("hold_idle", stat[0], S_IDLE);

        // inputs changed during BUSY are ignored
        access(0, WR, 32'h20, 32'h77, bw);
        @(negedge clk);
        ctrl[0] = WR; addr[0] = 32'h30; wd[0] = 32'h1234;
        @(negedge clk);
        addr[0] = 32'h20; wd[0] = 32'h1;
        wait_done(0, bw);
        ctrl[0] = NONE;
        @(negedge clk);
        access(0, RD, 32'h30, 32'h0, bw);
        chk("latched_30", rdata[0], 32'h1234);
        access(0, RD, 32'h20, 32'h0, bw);
        chk("untouched_20", rdata[0], 32'h77);
        access(0, WR, 32'h5, 32'h9, bw);
        chk("rdata_hold_wr", rdata[0], 32'h77);

        // address wrap and latency sweep
        access(0, WR, 32'd1028, 32'hA5, bw);
        access(0, RD, 32'd4, 32'h0, bw);
        chk("wrap_rd", rdata[0], 32'hA5);
        access(1, WR, 32'd7, 32'hCAFE, bw);
        chk("lat1_busy", bw, 1);
        access(1, RD, 32'd7, 32'h0, bw);
        chk("lat1_rd", rdata[1], 32'hCAFE);
        access(2, WR, 32'd9, 32'hBEEF, bw);
        chk("lat255_busy", bw, 255);
        access(2, RD, 32'd9, 32'h0, bw);
        chk("lat255_rd", rdata[2], 32'hBEEF);

        // counter saturation and unknown command
        for (int i = 0; i < 2; i++) access(3, RD, 32'd0, 32'h0, bw);
        chk("sat_rdc2", 32'(s_rdc), 32'd2);
        for (int i = 0; i < 3; i++) access(3, RD, 32'd0, 32'h0, bw);
        chk("sat_rdc5", 32'(s_rdc), 32'd3);
        chk("sat_wrc", 32'(s_wrc), 32'd0);
        @(negedge clk);
        ctrl[3] = 32'd3;
        repeat (3) @(negedge clk);
        chk("unk3_idle", stat[3], S_IDLE);
        ctrl[3] = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("unkF_idle", stat[3], S_IDLE);
        ctrl[3] = NONE;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
